// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : shared memory-port indices and arbiter FSM encoding
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mux21_bus.sv
// ============================================================================
// mux21_bus : WIDTH-parameterised 2:1 bus multiplexer (s0=0 selects in0)
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module mux21_bus #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             s0
);

  assign out = s0 ? in1 : in0;

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : round-robin share of one memory port between fetch and data
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] addr0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr1,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             timeout_err
);

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_nx;
  logic             last, last_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sel_nx, gnt0_nx, gnt1_nx, mem_req_nx;
  logic             done0_nx, done1_nx, timeout_nx;
  logic             winner;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= PORT_DATA;
      cnt         <= '0;
      sel         <= PORT_IF;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      mem_req     <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last        <= last_nx;
      cnt         <= cnt_nx;
      sel         <= sel_nx;
      gnt0        <= gnt0_nx;
      gnt1        <= gnt1_nx;
      mem_req     <= mem_req_nx;
      done0       <= done0_nx;
      done1       <= done1_nx;
      timeout_err <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_nx    = last;
    cnt_nx     = cnt;
    sel_nx     = sel;
    gnt0_nx    = gnt0;
    gnt1_nx    = gnt1;
    mem_req_nx = mem_req;
    done0_nx   = 1'b0;
    done1_nx   = 1'b0;
    timeout_nx = 1'b0;
    winner     = last;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port not served last goes next.
          winner     = (req0 && req1) ? ~last : req1;
          state_nx   = BUSY;
          sel_nx     = winner;
          gnt0_nx    = (winner == PORT_IF);
          gnt1_nx    = (winner == PORT_DATA);
          mem_req_nx = 1'b1;
          cnt_nx     = '0;
        end
      end
      BUSY: begin
        // mem_ready takes priority over an expiring watchdog.
        if (mem_ready || (cnt == CNT_MAX)) begin
          done0_nx   = mem_ready && (sel == PORT_IF);
          done1_nx   = mem_ready && (sel == PORT_DATA);
          timeout_nx = !mem_ready;
          gnt0_nx    = 1'b0;
          gnt1_nx    = 1'b0;
          mem_req_nx = 1'b0;
          last_nx    = sel;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  mux21_bus #(
    .WIDTH(WIDTH)
  ) u_addr_mux (
    .out(mem_addr),
    .in0(addr0),
    .in1(addr1),
    .s0 (sel)
  );

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single memory port of the MIPS core between instruction fetch (port 0) and data load/store (port 1). It owns the select line of the 2:1 address multiplexer in front of memory. It issues one access at a time, pairs each access with a `mem_ready` handshake, and alternates fairly between the ports when both request. A watchdog aborts any access that memory never acknowledges.

## Interface
Parameters:
- `WIDTH`, 32: address width.
- `TIMEOUT`, 15: maximum cycles `mem_req` stays high without `mem_ready`. Legal range is ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `req0`  in  1  port 0 (instruction fetch) request.
- `addr0`  in  WIDTH  port 0 address; held stable while `gnt0`.
- `req1`  in  1  port 1 (data) request.
- `addr1`  in  WIDTH  port 1 address; held stable while `gnt1`.
- `mem_ready`  in  1  memory has completed the current access.
- `mem_req`  out  1  access in progress toward memory.
- `mem_addr`  out  WIDTH  muxed address: `addr0` when `sel`=0, `addr1` when `sel`=1.
- `sel`  out  1  mux select; 0 = port 0.
- `gnt0`, `gnt1`  out  1  grant; one-hot or zero.
- `done0`, `done1`  out  1  one-cycle completion pulse to the owning port.
- `timeout_err`  out  1  one-cycle pulse when an access is aborted.

## Operation
- FSM has two states: IDLE and BUSY. Register `last` holds the port that was most recently served.
- **IDLE arbitration**:
  - Requests are sampled only in IDLE.
  - Only `req0` high: winner = 0. Only `req1` high: winner = 1.
  - Both high: winner = `!last` (round-robin).
  - Neither high: stay in IDLE.
  - On a win: go to BUSY, latch `sel` = winner, set `gnt_winner`=1 and `mem_req`=1, clear the watchdog counter.
- **BUSY**:
  - `mem_req`, `sel` and the grant are held.
  - Requests are ignored. A requester dropping `req` mid-access does not cancel the access.
  - `mem_ready`=1: pulse `done_sel`, drop the grant and `mem_req`, set `last`=`sel`, return to IDLE.
  - `mem_ready`=0 with counter == `TIMEOUT`-1: pulse `timeout_err` with no done pulse, drop the grant and `mem_req`, set `last`=`sel`, return to IDLE.
  - Otherwise the counter increments.
- `mem_ready` and the timeout in the same cycle: `mem_ready` wins, and the access completes normally.
- `mem_ready` while in IDLE is ignored.
- `mem_addr` is combinational from `sel` and `addr0`/`addr1`. `sel` only changes on entry to BUSY.
- Counter width is `$clog2(TIMEOUT)`. It never wraps, because it is cleared on BUSY entry and BUSY exits at `TIMEOUT`-1.

## Timing
- **Reset values**: state IDLE, `last`=1 (port 0 wins the first tie), and `sel`, `gnt0`, `gnt1`, `mem_req`, `done0`, `done1`, `timeout_err` and the counter all 0.
- **Grant latency**: a request sampled at edge N gives grant and `mem_req` high from edge N onward, visible during cycle N+1.
- **Completion latency**: `mem_ready` sampled high at edge M gives the done pulse, grant low and `mem_req` low during cycle M+1.
- **Back-to-back accesses**: at least one IDLE cycle lies between accesses. Minimum access length with `mem_ready` already high is 1 BUSY cycle, so the fastest issue rate is one access per 2 cycles.
- **Timeout**: `mem_req` stays high for exactly `TIMEOUT` cycles, then `timeout_err` pulses in the following cycle.
- **Reset mid-access**: the access is aborted at that edge and all outputs return to reset values. No done pulse and no `timeout_err` are produced.

## Structure
- The shared `mips_pkg` holds the port index constants `PORT_IF`=0 and `PORT_DATA`=1 and the FSM state encoding (IDLE, BUSY).
- The address path is one sub-module, `mux21_bus`: a WIDTH-parameterised 2:1 mux with ports `out`, `in0`, `in1`, `s0`. `sel` drives `s0`.

## Test plan
- **Single port 0**: `req0`=1, `addr0`=0x00400000, `mem_ready` high on the 3rd BUSY cycle -> `gnt0`/`mem_req` high for 3 cycles, `mem_addr`=0x00400000, `done0` pulses once, `sel`=0 throughout.
- **Tie after reset**: `req0`=`req1`=1 held, `mem_ready` tied 1 -> grants alternate 0,1,0,1 with one IDLE cycle between them, and `done0`/`done1` alternate.
- **Data then contended**: `req1` alone, then both requesting -> first grant to 1, next grant to 0.
- **Timeout**: `TIMEOUT`=15, `req1`=1, `mem_ready`=0 -> `mem_req` high for 15 cycles, then a single `timeout_err` pulse, no `done1`, and port 0 wins the next tie.
- **Simultaneous ready and timeout**: `mem_ready` rises in BUSY cycle 15 -> `done` pulses and `timeout_err` stays 0.
- **Reset mid-access**: `rst_n`=0 in BUSY cycle 2 -> next cycle all outputs 0, no `done`, and port 0 wins the next tie.
